// File: rtl/lbist_boot_seq.sv
// lbist_boot_seq: runs per-core LBIST, releases passing cores from reset and supervises their run to exit or timeout.
// Define LBIST_MMAP_CHECK_EN to flag out-of-window DRAM writes while cores run.
module lbist_boot_seq #(
  parameter int          NUM_CORES    = 2,
  parameter int          RST_CYCLES   = 4,
  parameter int          BIST_TIMEOUT = 4096,
  parameter int          RUN_TIMEOUT  = 5000,
  parameter logic [31:0] DRAM_LO      = 32'h200000,
  parameter logic [31:0] DRAM_HI      = 32'h240000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [NUM_CORES-1:0]    bist_done_i,
  input  logic [NUM_CORES-1:0]    go_nogo_i,
  input  logic [NUM_CORES-1:0]    exit_valid_i,
  input  logic [NUM_CORES-1:0]    data_req_i,
  input  logic [NUM_CORES-1:0]    data_we_i,
  input  logic [32*NUM_CORES-1:0] data_addr_i,
  output logic [NUM_CORES-1:0]    test_mode_o,
  output logic [NUM_CORES-1:0]    core_rst_n_o,
  output logic [NUM_CORES-1:0]    fetch_enable_o,
  output logic [NUM_CORES-1:0]    bist_pass_o,
  output logic [NUM_CORES-1:0]    mmap_viol_o,
  output logic [2:0]              state_o,
  output logic                    timeout_o,
  output logic                    done_o
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] BIST     = 3'd1;
  localparam logic [2:0] SETTLE   = 3'd2;
  localparam logic [2:0] CORE_RST = 3'd3;
  localparam logic [2:0] RUN      = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
  localparam logic [2:0] FAIL     = 3'd6;
  localparam int CMAX = BIST_TIMEOUT > RUN_TIMEOUT ? BIST_TIMEOUT : RUN_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  logic [2:0]           state, state_nx;
  logic [CW-1:0]        cnt;
  logic [31:0]          cnt32;
  logic [NUM_CORES-1:0] exit_mask, exit_nx;
  logic                 go, all_done, exited, bist_to, run_to;
  assign cnt32    = 32'(cnt);
  assign go       = start_i && (state == IDLE || state == DONE || state == FAIL);
  assign all_done = &bist_done_i;
  assign exit_nx  = exit_mask | exit_valid_i;
  assign exited   = (exit_nx & bist_pass_o) == bist_pass_o;
  assign bist_to  = cnt32 == 32'(BIST_TIMEOUT - 1);
  assign run_to   = cnt32 == 32'(RUN_TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE, FAIL: state_nx = start_i ? BIST : state;
      BIST:             state_nx = all_done ? SETTLE : bist_to ? FAIL : BIST;
      SETTLE:           state_nx = cnt32 == 32'd1 ? (|bist_pass_o ? CORE_RST : FAIL) : SETTLE;
      CORE_RST:         state_nx = cnt32 == 32'(RST_CYCLES - 1) ? RUN : CORE_RST;
      RUN:              state_nx = exited ? DONE : run_to ? FAIL : RUN;
      default:          state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      exit_mask   <= '0;
      bist_pass_o <= '0;
      timeout_o   <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= state_nx != state ? '0 : cnt == '1 ? cnt : cnt + 1'b1;
      exit_mask   <= go ? '0 : state == RUN ? exit_nx : exit_mask;
      bist_pass_o <= go ? '0 : state == BIST ? (bist_pass_o & ~bist_done_i) | (go_nogo_i & bist_done_i) : bist_pass_o;
      timeout_o   <= go ? 1'b0 : timeout_o | (state == BIST && !all_done && bist_to) | (state == RUN && !exited && run_to);
      done_o      <= go ? 1'b0 : done_o | (state == RUN && exited);
    end
  // Failed cores stay held in reset and never fetch.
  assign test_mode_o    = (state == BIST || state == SETTLE) ? '1 : '0;
  assign core_rst_n_o   = state == RUN ? bist_pass_o : '0;
  assign fetch_enable_o = state == RUN ? bist_pass_o : '0;
  assign state_o        = state;
`ifdef LBIST_MMAP_CHECK_EN
  logic [NUM_CORES-1:0] oob;
  always_comb begin
    oob = '0;
    for (int i = 0; i < NUM_CORES; i++)
      oob[i] = data_req_i[i] & data_we_i[i] &
               (data_addr_i[32*i +: 32] < DRAM_LO || data_addr_i[32*i +: 32] > DRAM_HI);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mmap_viol_o <= '0;
    else mmap_viol_o <= go ? '0 : mmap_viol_o | (state == RUN ? oob : '0);
`else
  logic unused_data;
  assign unused_data = ^{data_req_i, data_we_i, data_addr_i};
  assign mmap_viol_o = '0;
`endif
endmodule

// File: tb/tb_lbist_boot_seq.sv
// tb_lbist_boot_seq: directed and randomized boot sequences checked against a phase-timeline model.
module tb_lbist_boot_seq;
  localparam int          RC = 4;
  localparam int          BT = 16;
  localparam int          RT = 40;
  localparam logic [31:0] LO = 32'h200000;
  localparam logic [31:0] HI = 32'h240000;
  localparam logic [2:0] S_IDLE = 3'd0, S_BIST = 3'd1, S_SETTLE = 3'd2, S_CRST = 3'd3,
                         S_RUN = 3'd4, S_DONE = 3'd5, S_FAIL = 3'd6;
  logic        clk = 1'b0, rst_n = 1'b1, start_i = 1'b0;
  logic [1:0]  bist_done_i = '0, go_nogo_i = '0, exit_valid_i = '0, data_req_i = '0, data_we_i = '0;
  logic [63:0] data_addr_i = '0;
  logic [1:0]  test_mode_o, core_rst_n_o, fetch_enable_o, bist_pass_o, mmap_viol_o;
  logic [2:0]  state_o;
  logic        timeout_o, done_o;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  lbist_boot_seq #(.NUM_CORES(2), .RST_CYCLES(RC), .BIST_TIMEOUT(BT), .RUN_TIMEOUT(RT),
                   .DRAM_LO(LO), .DRAM_HI(HI)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .bist_done_i(bist_done_i), .go_nogo_i(go_nogo_i),
    .exit_valid_i(exit_valid_i), .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .test_mode_o(test_mode_o), .core_rst_n_o(core_rst_n_o), .fetch_enable_o(fetch_enable_o),
    .bist_pass_o(bist_pass_o), .mmap_viol_o(mmap_viol_o), .state_o(state_o),
    .timeout_o(timeout_o), .done_o(done_o));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_mm(input logic [1:0] v);
`ifdef LBIST_MMAP_CHECK_EN
    return v;
`else
    return 2'b00 & v;
`endif
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return LO - 1;
      1: return LO;
      2: return HI;
      3: return HI + 1;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_data();
    data_req_i = 2'($urandom);
    data_we_i  = 2'($urandom);
    for (int i = 0; i < 2; i++) data_addr_i[32*i +: 32] = pick_addr();
  endtask

  function automatic logic [1:0] bad_of();
    logic [1:0] b;
    for (int i = 0; i < 2; i++)
      b[i] = data_req_i[i] & data_we_i[i] & (data_addr_i[32*i +: 32] < LO || data_addr_i[32*i +: 32] > HI);
    return b;
  endfunction

  function automatic logic [14:0] all_out();
    return {state_o, test_mode_o, core_rst_n_o, fetch_enable_o, bist_pass_o, mmap_viol_o, timeout_o, done_o};
  endfunction

  // d0/d1: cycle after start at which each core's bist_done rises (0 = never); e0/e1: RUN cycle of exit pulse (0 = never)
  task automatic boot(input string tag, input int d0, input int d1, input logic [1:0] gng,
                      input int e0, input int e1, input bit hold_start, input bit mm);
    int bd, k, rc, need, kx;
    logic [1:0] viol;
    bit ok;
    viol = '0;
    ok = 1;
    bd = (d0 == 0 || d1 == 0) ? BT + 1 : (d0 > d1 ? d0 : d1);
    start_i = 1'b1;
    tick();
    start_i = hold_start;
    chk({tag, "_start"}, {state_o, test_mode_o, bist_pass_o, mmap_viol_o, timeout_o, done_o},
        {S_BIST, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0});
    for (k = 1; k <= BT; k++) begin
      bist_done_i = {1'(d1 != 0 && k >= d1), 1'(d0 != 0 && k >= d0)};
      go_nogo_i   = (k == bd) ? gng : 2'($urandom);
      rand_data();
      tick();
      if (k >= bd || k == BT) break;
      if (state_o != S_BIST || test_mode_o != 2'b11) ok = 0;
    end
    start_i = 1'b0;
    bist_done_i = '0;
    data_req_i = '0;
    data_we_i = '0;
    chk({tag, "_bist_hold"}, 32'(ok), 1);
    if (bd > BT) begin
      chk({tag, "_bist_to"}, {state_o, timeout_o, test_mode_o, done_o}, {S_FAIL, 1'b1, 2'b00, 1'b0});
      return;
    end
    chk({tag, "_settle1"}, {state_o, test_mode_o, bist_pass_o, timeout_o}, {S_SETTLE, 2'b11, gng, 1'b0});
    tick();
    chk({tag, "_settle2"}, {state_o, test_mode_o}, {S_SETTLE, 2'b11});
    tick();
    if (gng == 2'b00) begin
      chk({tag, "_nopass"}, {state_o, timeout_o, test_mode_o, done_o}, {S_FAIL, 1'b0, 2'b00, 1'b0});
      return;
    end
    chk({tag, "_corerst"}, {state_o, test_mode_o, core_rst_n_o, fetch_enable_o}, {S_CRST, 6'b0});
    rc = 1;
    for (int i = 0; i < RC + 2; i++) begin
      tick();
      if (state_o != S_CRST || core_rst_n_o != 2'b00) break;
      rc++;
    end
    chk({tag, "_rst_len"}, rc, RC);
    chk({tag, "_run_entry"}, {state_o, core_rst_n_o, fetch_enable_o}, {S_RUN, gng, gng});
    need = 0;
    if (gng[0]) need = (e0 == 0) ? RT + 1 : e0;
    if (gng[1]) need = ((e1 == 0) ? RT + 1 : e1) > need ? ((e1 == 0) ? RT + 1 : e1) : need;
    kx = need <= RT ? need : RT;
    for (k = 1; k <= RT + 2; k++) begin
      exit_valid_i = {1'(k == e1), 1'(k == e0)};
      if (mm) begin
        data_req_i = k <= 2 ? 2'b01 : 2'b00;
        data_we_i  = data_req_i;
        data_addr_i[31:0] = k == 1 ? HI : LO - 1;
      end else rand_data();
      if (k <= kx) viol |= bad_of();
      tick();
      if (mm && k == 1) chk({tag, "_mm_hi_edge"}, mmap_viol_o, 2'b00);
      if (mm && k == 2) chk({tag, "_mm_below"}, mmap_viol_o, exp_mm(2'b01));
      if (state_o != S_RUN) break;
      if (fetch_enable_o != gng || core_rst_n_o != gng) ok = 0;
    end
    exit_valid_i = '0;
    data_req_i = '0;
    data_we_i = '0;
    chk({tag, "_run_hold"}, 32'(ok), 1);
    chk({tag, "_run_len"}, k, kx);
    chk({tag, "_end"}, {state_o, done_o, timeout_o, test_mode_o, core_rst_n_o, fetch_enable_o, bist_pass_o},
        {need <= RT ? S_DONE : S_FAIL, 1'(need <= RT), 1'(need > RT), 6'b0, gng});
    chk({tag, "_mmap"}, mmap_viol_o, exp_mm(viol));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("reset_async", all_out(), 0);
    tick();
    tick();
    chk("reset_held", all_out(), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("idle_no_start", all_out(), 0);
    boot("nom", 10, 10, 2'b11, 5, 7, 0, 0);
    boot("c1fail", 4, 6, 2'b01, 3, 0, 0, 1);
    boot("bto", 0, 0, 2'b11, 1, 1, 1, 0);
    boot("bedge", 16, 16, 2'b10, 4, 2, 0, 0);
    boot("nopass", 2, 3, 2'b00, 1, 1, 0, 0);
    boot("rto", 1, 1, 2'b11, 0, 5, 0, 0);
    boot("redge", 2, 2, 2'b11, RT, 3, 0, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    bist_done_i = 2'b11;
    go_nogo_i = 2'b11;
    tick();
    bist_done_i = '0;
    tick();
    tick();
    chk("mid_crst", state_o, S_CRST);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_crst", all_out(), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_after_rst", all_out(), 0);
    boot("after_rst", 3, 5, 2'b11, 6, 2, 0, 0);
    for (int n = 0; n < 8; n++)
      boot($sformatf("rnd%0d", n), $urandom_range(1, 18), $urandom_range(1, 18), 2'($urandom),
           $urandom_range(0, RT + 3), $urandom_range(0, RT + 3), 1'($urandom), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
